// File: rtl/maze_probe_if.sv
// Command handshake and memory port bundle between the maze solver, maze_probe and the 16x16 maze memory.
`timescale 1ns/1ps
interface maze_probe_if;
    logic       start;
    logic [1:0] cmd;
    logic [3:0] x_in;
    logic [3:0] y_in;
    logic [1:0] dir;
    logic       wdata;
    logic       busy;
    logic       done;
    logic [3:0] free_mask;
    logic       oob;
    logic       mem_rd;
    logic       mem_wr;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic       mem_din;
    logic       mem_dout;

    modport master (
        output start, cmd, x_in, y_in, dir, wdata, mem_dout,
        input  busy, done, free_mask, oob, mem_rd, mem_wr, mem_x, mem_y, mem_din
    );

    modport slave (
        input  start, cmd, x_in, y_in, dir, wdata, mem_dout,
        output busy, done, free_mask, oob, mem_rd, mem_wr, mem_x, mem_y, mem_din
    );
endinterface

// File: rtl/maze_probe.sv
// Maze memory requester: PROBE / WRITE / SCAN neighbour queries on a 16x16 wall map.
// Optional read statistics counter enabled by defining MAZE_PROBE_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for start, command inputs latched on acceptance
// SEL    | neighbour for current direction computed, bounds checked
// RD     | mem_rd held READ_LAT+1 cycles, data sampled on the last one
// WR     | single mem_wr cycle at the latched cell
// NEXT   | SCAN direction step, finishes after direction 3
// DONE   | one-cycle done pulse
`timescale 1ns/1ps
module maze_probe #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    maze_probe_if.slave bus,
    output logic [15:0] rd_count
);
    localparam logic [1:0] CMD_PROBE = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] LAT       = 2'(READ_LAT);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_RD, S_WR, S_NEXT, S_DONE} state_t;

    state_t     state;
    logic [1:0] op;
    logic [3:0] cx, cy;
    logic [1:0] cdir;
    logic [1:0] lat_cnt;
    logic [4:0] nx, ny;
    logic       n_oob;
    logic       busy_r, done_r, oob_r, rd_r, wr_r, din_r;
    logic [3:0] mask_r, mx_r, my_r;

    // Both -1 (5'h1F) and 16 (5'h10) carry bit 4, so it alone flags out of bounds.
    always_comb begin
        nx = {1'b0, cx};
        ny = {1'b0, cy};
        case (cdir)
            2'd0:    nx = {1'b0, cx} + 5'd1;
            2'd1:    ny = {1'b0, cy} + 5'd1;
            2'd2:    nx = {1'b0, cx} - 5'd1;
            default: ny = {1'b0, cy} - 5'd1;
        endcase
        n_oob = nx[4] | ny[4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op      <= '0;
            cx      <= '0;
            cy      <= '0;
            cdir    <= '0;
            lat_cnt <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            oob_r   <= 1'b0;
            mask_r  <= '0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            din_r   <= 1'b0;
            mx_r    <= '0;
            my_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op     <= bus.cmd;
                        cx     <= bus.x_in;
                        cy     <= bus.y_in;
                        cdir   <= (bus.cmd == CMD_PROBE) ? bus.dir : 2'd0;
                        mask_r <= '0;
                        oob_r  <= 1'b0;
                        busy_r <= 1'b1;
                        if (bus.cmd == CMD_WRITE) begin
                            wr_r  <= 1'b1;
                            mx_r  <= bus.x_in;
                            my_r  <= bus.y_in;
                            din_r <= bus.wdata;
                            state <= S_WR;
                        end else begin
                            state <= S_SEL;
                        end
                    end
                end
                S_SEL: begin
                    if (n_oob) begin
                        if (op == CMD_PROBE) begin
                            oob_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else begin
                        rd_r    <= 1'b1;
                        mx_r    <= nx[3:0];
                        my_r    <= ny[3:0];
                        lat_cnt <= LAT;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (lat_cnt == 2'd0) begin
                        mask_r[cdir] <= ~bus.mem_dout;
                        rd_r         <= 1'b0;
                        if (op == CMD_PROBE) begin
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_WR: begin
                    wr_r   <= 1'b0;
                    done_r <= 1'b1;
                    state  <= S_DONE;
                end
                S_NEXT: begin
                    if (cdir == 2'd3) begin
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cdir  <= cdir + 2'd1;
                        state <= S_SEL;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAZE_PROBE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_count <= '0;
        else if (state == S_SEL && !n_oob && rd_count != 16'hFFFF)
            rd_count <= rd_count + 16'd1;
    end
`else
    assign rd_count = '0;
`endif

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.free_mask = mask_r;
    assign bus.oob       = oob_r;
    assign bus.mem_rd    = rd_r;
    assign bus.mem_wr    = wr_r;
    assign bus.mem_x     = mx_r;
    assign bus.mem_y     = my_r;
    assign bus.mem_din   = din_r;
endmodule

// File: tb/tb_maze_probe.sv
// Bench for maze_probe: cycle-level expected schedule built from the command timing rules, plus pinned scenarios.
`timescale 1ns/1ps
module tb_maze_probe;
    localparam int READ_LAT = 1;

    logic        clk;
    logic        rst;
    logic [15:0] rd_count;
    maze_probe_if bif ();

    maze_probe #(.READ_LAT(READ_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory seen by the DUT, and the bench's own view of what it must contain.
    logic [255:0] maze_mem;
    logic [255:0] ref_maze;
    int           rd_run = 0;
    logic         garbage = 1'b0;

    always @(negedge clk) garbage <= $urandom_range(0, 1) != 0;
    always @(posedge clk) begin
        if (bif.mem_wr) maze_mem[{bif.mem_x, bif.mem_y}] <= bif.mem_din;
        rd_run <= bif.mem_rd ? rd_run + 1 : 0;
    end
    // Before the latency expires the bus shows the inverse of the stored bit.
    assign bif.mem_dout = !bif.mem_rd ? garbage :
                          (rd_run >= READ_LAT) ? maze_mem[{bif.mem_x, bif.mem_y}]
                                               : ~maze_mem[{bif.mem_x, bif.mem_y}];

    task automatic set_cell(input int x, input int y, input logic v);
        maze_mem[x*16+y] = v;
        ref_maze[x*16+y] = v;
    endtask

    // Reference model: one expected entry per cycle after acceptance.
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       dn;
        logic [3:0] x;
        logic [3:0] y;
        logic       din;
    } ent_t;

    ent_t        exp_q[$];
    logic [3:0]  m_mask = '0;
    logic        m_oob = 1'b0;
    int          exp_rd_cnt = 0;
    int          accepts = 0;
    int          dones_seen = 0;

    function automatic void push(bit rd, bit wr, bit dn, int x, int y, bit din);
        ent_t e;
        e.rd = rd; e.wr = wr; e.dn = dn;
        e.x = 4'(x); e.y = 4'(y); e.din = din;
        exp_q.push_back(e);
    endfunction

    function automatic void build(logic [1:0] c, logic [3:0] x, logic [3:0] y, logic [1:0] d, logic w);
        int tx, ty, dd;
        bit inb;
        accepts++;
        m_mask = '0;
        m_oob  = 1'b0;
        if (c == 2'b01) begin
            push(0, 1, 0, int'(x), int'(y), w);
            push(0, 0, 1, 0, 0, 0);
            ref_maze[int'(x)*16+int'(y)] = w;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (c == 2'b00 && k > 0) break;
            dd = (c == 2'b00) ? int'(d) : k;
            tx = int'(x) + (dd == 0 ? 1 : 0) - (dd == 2 ? 1 : 0);
            ty = int'(y) + (dd == 1 ? 1 : 0) - (dd == 3 ? 1 : 0);
            inb = tx >= 0 && tx < 16 && ty >= 0 && ty < 16;
            push(0, 0, 0, 0, 0, 0);
            if (inb) begin
                for (int j = 0; j <= READ_LAT; j++) push(1, 0, 0, tx, ty, 0);
                m_mask[dd] = !ref_maze[tx*16+ty];
                if (exp_rd_cnt < 65535) exp_rd_cnt++;
            end else if (c == 2'b00) begin
                m_oob = 1'b1;
            end
            if (c != 2'b00) push(0, 0, 0, 0, 0, 0);
        end
        push(0, 0, 1, 0, 0, 0);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_mask     = '0;
            m_oob      = 1'b0;
            exp_rd_cnt = 0;
        end else if (exp_q.size() == 0) begin
            if (bif.start) build(bif.cmd, bif.x_in, bif.y_in, bif.dir, bif.wdata);
        end else begin
            void'(exp_q.pop_front());
        end
    end

    function automatic int exp_rd_view();
`ifdef MAZE_PROBE_STATS_EN
        return exp_rd_cnt;
`else
        return 0;
`endif
    endfunction

    // Per-cycle compare, mid-cycle.
    always @(negedge clk) begin
        ent_t e;
        bit   act;
        if (rst) begin
            act = exp_q.size() > 0;
            e = act ? exp_q[0] : '0;
            if (bif.done) dones_seen++;
            check("busy", 32'(bif.busy), 32'(act));
            check("done", 32'(bif.done), 32'(e.dn));
            check("mem_rd", 32'(bif.mem_rd), 32'(e.rd));
            check("mem_wr", 32'(bif.mem_wr), 32'(e.wr));
            if (e.rd || e.wr) begin
                check("mem_x", 32'(bif.mem_x), 32'(e.x));
                check("mem_y", 32'(bif.mem_y), 32'(e.y));
            end
            if (e.wr) check("mem_din", 32'(bif.mem_din), 32'(e.din));
            if (!act || e.dn) begin
                check("free_mask", 32'(bif.free_mask), 32'(m_mask));
                check("oob", 32'(bif.oob), 32'(m_oob));
            end
            if (!act) check("rd_count", 32'(rd_count), 32'(exp_rd_view()));
        end
    end

    // Issue one command from an idle cycle (#1 after posedge); returns done cycle index.
    task automatic run_cmd(input logic [1:0] c, input int x, input int y, input logic [1:0] d,
                           input logic w, output int lat, output logic [3:0] mask, output logic o);
        bif.start = 1'b1;
        bif.cmd   = c;
        bif.x_in  = 4'(x);
        bif.y_in  = 4'(y);
        bif.dir   = d;
        bif.wdata = w;
        @(posedge clk);
        #1 bif.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bif.done) begin
                lat = n;
                break;
            end
        end
        mask = bif.free_mask;
        o    = bif.oob;
        if (lat < 0) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bif.busy), 0);
        check({tag, "_done"}, 32'(bif.done), 0);
        check({tag, "_mem_rd"}, 32'(bif.mem_rd), 0);
        check({tag, "_mem_wr"}, 32'(bif.mem_wr), 0);
        check({tag, "_mem_xy"}, {24'd0, bif.mem_x, bif.mem_y}, 0);
        check({tag, "_mem_din"}, 32'(bif.mem_din), 0);
        check({tag, "_mask_oob"}, {27'd0, bif.free_mask, bif.oob}, 0);
        check({tag, "_rd_count"}, 32'(rd_count), 0);
    endtask

    int         lat;
    logic [3:0] mask;
    logic       o;
    int         rc0;
    int         acc0, done0;
    bit         hit;

    initial begin
        rst = 1'b0;
        bif.start = 1'b0; bif.cmd = '0; bif.x_in = '0; bif.y_in = '0; bif.dir = '0; bif.wdata = 1'b0;
        maze_mem = '0;
        ref_maze = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // WRITE then PROBE onto the freshly written wall.
        run_cmd(2'b01, 0, 3, 2'd0, 1'b1, lat, mask, o);
        check("write_done_cycle", 32'(lat), 2);
        run_cmd(2'b00, 0, 2, 2'd1, 1'b0, lat, mask, o);
        check("probe_done_cycle", 32'(lat), 4);
        check("probe_mask", 32'(mask), 32'h0);
        check("probe_oob", 32'(o), 0);

        // PROBE off the right edge.
        run_cmd(2'b00, 15, 7, 2'd0, 1'b0, lat, mask, o);
        check("oob_done_cycle", 32'(lat), 2);
        check("oob_flag", 32'(o), 1);

        // SCAN an interior cell with walls to the east and north(y-1).
        set_cell(6, 5, 1'b1);
        set_cell(5, 4, 1'b1);
        run_cmd(2'b10, 5, 5, 2'd0, 1'b0, lat, mask, o);
        check("scan_mid_mask", 32'(mask), 32'h6);
        check("scan_mid_done_cycle", 32'(lat), 17);

        // SCAN the corner on an empty maze.
        maze_mem = '0;
        ref_maze = '0;
        rc0 = int'(rd_count);
        run_cmd(2'b11, 0, 0, 2'd2, 1'b0, lat, mask, o);
        check("scan_corner_mask", 32'(mask), 32'h3);
        check("scan_corner_done_cycle", 32'(lat), 13);
`ifdef MAZE_PROBE_STATS_EN
        check("scan_corner_rd_delta", 32'(int'(rd_count) - rc0), 2);
`else
        check("scan_corner_rd_delta", 32'(int'(rd_count) - rc0), 0);
`endif

        // Abort a SCAN with reset while reading.
        bif.start = 1'b1; bif.cmd = 2'b10; bif.x_in = 4'd7; bif.y_in = 4'd7;
        @(posedge clk);
        #1 bif.start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bif.mem_rd) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_saw_rd", 32'(hit), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_cell(8, 7, 1'b1);
        run_cmd(2'b00, 7, 7, 2'd0, 1'b0, lat, mask, o);
        check("after_abort_done_cycle", 32'(lat), 4);
        check("after_abort_mask", 32'(mask), 32'h0);

        // Randomised commands on a random maze.
        for (int i = 0; i < 90; i++) begin
            if (i % 20 == 0)
                for (int c = 0; c < 256; c++) set_cell(c / 16, c % 16, $urandom_range(0, 2) == 0);
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
                    2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, lat, mask, o);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // start held high through a PROBE with inputs changing every cycle.
        acc0  = accepts;
        done0 = dones_seen;
        bif.start = 1'b1; bif.cmd = 2'b00; bif.x_in = 4'd3; bif.y_in = 4'd3; bif.dir = 2'd1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            bif.cmd  = 2'($urandom_range(0, 1) * 2);
            bif.x_in = 4'($urandom_range(0, 15));
            bif.y_in = 4'($urandom_range(0, 15));
            bif.dir  = 2'($urandom_range(0, 3));
        end
        bif.start = 1'b0;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        check("pulse_drained", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        check("pulse_multi_accept", 32'(accepts - acc0 >= 2), 1);
        check("pulse_done_per_cmd", 32'(dones_seen - done0), 32'(accepts - acc0));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
